// File: rtl/fxp_addsub_pipe.sv
// Pipelined signed fixed-point adder/subtractor built on a radix-2 group carry-lookahead tree,
// with a valid/ready handshake, optional saturation and a saturating overflow event counter.
module fxp_addsub_pipe #(
  parameter int WIDTH = 64,
  parameter int GROUP = 2,
  parameter int PIPE  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_sat,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_count
);

  localparam int NG        = WIDTH / GROUP;
  localparam int LV        = $clog2(NG);
  localparam int FIRST_REG = LV + 1 - PIPE;

  localparam int OFF_P  = 0;
  localparam int OFF_G  = NG;
  localparam int OFF_SM = 2 * NG;
  localparam int OFF_C0 = 2 * NG + 1;
  localparam int OFF_B  = 2 * NG + 2;
  localparam int OFF_A  = 2 * NG + 2 + WIDTH;
  localparam int PW     = 2 * NG + 2 + 2 * WIDTH;

  logic             adv;
  logic [WIDTH-1:0] b_x;
  logic             c0;
  logic [NG-1:0]    leaf_g;
  logic [NG-1:0]    leaf_p;

  // One global enable: the whole pipe moves only when the output slot is free or being taken.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  assign b_x = in_mode[0] ? ~in_b : in_b;
  assign c0  = in_mode[0] ? ~in_carry : in_carry;

  function automatic logic [1:0] group_gp(input logic [GROUP-1:0] gv, input logic [GROUP-1:0] pv);
    logic gg;
    logic pp;
    gg = 1'b0;
    pp = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      gg = gv[i] | (pv[i] & gg);
      pp = pp & pv[i];
    end
    return {gg, pp};
  endfunction

  always_comb begin
    leaf_g = '0;
    leaf_p = '0;
    for (int j = 0; j < NG; j++) begin
      {leaf_g[j], leaf_p[j]} = group_gp(in_a[j*GROUP +: GROUP] & b_x[j*GROUP +: GROUP],
                                        in_a[j*GROUP +: GROUP] ^ b_x[j*GROUP +: GROUP]);
    end
  end

  // Level k of the prefix tree combines each group with the one 2^(k-1) below it; a register
  // may follow any level, and the last PIPE levels are the ones that get one.
  for (genvar k = 0; k <= LV; k++) begin : g_stage
    logic [PW-1:0] y;
    logic [PW-1:0] z;
    logic          y_vld;
    logic          z_vld;

    if (k == 0) begin : g_leaf
      assign y     = {in_a, b_x, c0, in_mode[1], leaf_g, leaf_p};
      assign y_vld = in_valid;
    end else begin : g_tree
      localparam int SPAN = 1 << (k - 1);
      logic [NG-1:0] gi;
      logic [NG-1:0] pin;
      logic [NG-1:0] go;
      logic [NG-1:0] po;

      assign gi  = g_stage[k-1].z[OFF_G +: NG];
      assign pin = g_stage[k-1].z[OFF_P +: NG];

      always_comb begin
        go = gi;
        po = pin;
        for (int i = SPAN; i < NG; i++) begin
          go[i] = gi[i] | (pin[i] & gi[i-SPAN]);
          po[i] = pin[i] & pin[i-SPAN];
        end
      end

      assign y     = {g_stage[k-1].z[PW-1:2*NG], go, po};
      assign y_vld = g_stage[k-1].z_vld;
    end

    if (k >= FIRST_REG) begin : g_reg
      // Data only loads with a valid beat so idle inputs never disturb the held result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          z     <= '0;
          z_vld <= 1'b0;
        end else if (adv) begin
          z_vld <= y_vld;
          if (y_vld) begin
            z <= y;
          end
        end
      end
    end else begin : g_wire
      assign z     = y;
      assign z_vld = y_vld;
    end
  end

  logic [WIDTH-1:0] fa;
  logic [WIDTH-1:0] fb;
  logic             fc0;
  logic             fsm;
  logic [NG-1:0]    pg;
  logic [NG-1:0]    pp;
  logic [NG-1:0]    gcar;
  logic             tree_cout;
  logic [WIDTH-1:0] s_raw;
  logic             c_msb_in;
  logic             ovf;
  logic [WIDTH-1:0] sat_val;

  assign fa  = g_stage[LV].z[OFF_A +: WIDTH];
  assign fb  = g_stage[LV].z[OFF_B +: WIDTH];
  assign fc0 = g_stage[LV].z[OFF_C0];
  assign fsm = g_stage[LV].z[OFF_SM];
  assign pg  = g_stage[LV].z[OFF_G +: NG];
  assign pp  = g_stage[LV].z[OFF_P +: NG];

  always_comb begin
    gcar    = '0;
    gcar[0] = fc0;
    for (int j = 1; j < NG; j++) begin
      gcar[j] = pg[j-1] | (pp[j-1] & fc0);
    end
  end

  assign tree_cout = pg[NG-1] | (pp[NG-1] & fc0);

  always_comb begin : p_sum
    logic c;
    c        = 1'b0;
    s_raw    = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i % GROUP == 0) begin
        c = gcar[i / GROUP];
      end
      s_raw[i] = fa[i] ^ fb[i] ^ c;
      if (i == WIDTH - 1) begin
        c_msb_in = c;
      end
      c = (fa[i] & fb[i]) | ((fa[i] ^ fb[i]) & c);
    end
  end

  // Overflow only happens when A and B' share a sign, so A's sign picks the clamp direction.
  assign ovf     = c_msb_in ^ tree_cout;
  assign sat_val = fa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

  assign out_valid    = g_stage[LV].z_vld;
  assign out_s        = (fsm & ovf) ? sat_val : s_raw;
  assign out_carry    = tree_cout;
  assign out_overflow = ovf;
  assign out_sat      = fsm & ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (clr_count) begin
      ovf_count <= '0;
    end else if (out_valid && out_ready && ovf && (ovf_count != {CNT_W{1'b1}})) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fxp_addsub_pipe.sv
// Scoreboard bench for fxp_addsub_pipe: expected results come from exact signed/unsigned
// arithmetic and are matched in order against delivered beats by an independent monitor.
module tb_fxp_addsub_pipe;

  localparam int WIDTH   = 64;
  localparam int GROUP   = 2;
  localparam int PIPE    = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  localparam logic signed [65:0] S_MAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] S_MIN = 66'sh3_8000_0000_0000_0000;

  typedef struct packed {
    logic [63:0] s;
    logic        carry;
    logic        ovf;
    logic        sat;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_carry;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic             out_carry;
  logic             out_overflow;
  logic             out_sat;
  logic [CNT_W-1:0] ovf_count;
  logic             clr_count;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ref_cnt  = 0;
  bit   rnd_run  = 0;

  fxp_addsub_pipe #(.WIDTH(WIDTH), .GROUP(GROUP), .PIPE(PIPE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_carry(in_carry), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_carry(out_carry), .out_overflow(out_overflow), .out_sat(out_sat),
    .ovf_count(ovf_count), .clr_count(clr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact result of A +/- (B + carry), then wrap or clamp to the 64-bit signed range.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic [1:0] mode);
    logic signed [65:0] ea, eb, ec, ex;
    logic [65:0] ua, ub, uc;
    exp_t e;
    ea = {{2{a[63]}}, a};
    eb = {{2{b[63]}}, b};
    ec = {65'd0, cin};
    ex = mode[0] ? (ea - eb - ec) : (ea + eb + ec);
    ua = {2'b00, a};
    ub = {2'b00, b};
    uc = {65'd0, cin};
    e.carry = mode[0] ? (ua >= ub + uc) : ((ua + ub + uc) >= (66'd1 << 64));
    e.ovf   = (ex > S_MAX) || (ex < S_MIN);
    e.sat   = e.ovf && mode[1];
    if (e.sat) e.s = (ex > S_MAX) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
    else       e.s = ex[63:0];
    return e;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic [1:0] mode);
    bit acc;
    acc      = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_carry = cin;
    in_mode  = mode;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(a, b, cin, mode));
        acc = 1;
      end
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a     = {$urandom, $urandom};
    in_b     = {$urandom, $urandom};
    in_carry = 1'($urandom_range(0, 1));
    in_mode  = 2'($urandom_range(0, 3));
  endtask

  task automatic check_latency();
    repeat (PIPE - 1) begin
      @(negedge clk);
      check_output("latency_early", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    check_output("latency_due", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 1000; t++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(posedge clk);
    #1;
    check_output("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1:       return 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 15));
      2:       return 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 15));
      default: return 64'($urandom_range(0, 1000));
    endcase
  endfunction

  // Monitor: pops on every delivery and tracks the expected overflow counter independently.
  always @(negedge clk) begin
    exp_t e;
    logic pop_ovf;
    pop_ovf = 1'b0;
    if (!rst_n) begin
      ref_cnt = 0;
    end else begin
      check_output("ovf_count", 64'(ovf_count), 64'(ref_cnt));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_beat: got out_s=%h, expected no beat", out_s);
        end else begin
          e = exp_q.pop_front();
          check_output("out_s", out_s, e.s);
          check_output("out_carry", 64'(out_carry), 64'(e.carry));
          check_output("out_overflow", 64'(out_overflow), 64'(e.ovf));
          check_output("out_sat", 64'(out_sat), 64'(e.sat));
          pop_ovf = e.ovf;
        end
      end
      if (clr_count) ref_cnt = 0;
      else if (pop_ovf && ref_cnt < CNT_MAX) ref_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected end within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_carry  = 1'b0;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    clr_count = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_out_s", out_s, 64'd0);
    check_output("rst_out_carry", 64'(out_carry), 64'd0);
    check_output("rst_out_overflow", 64'(out_overflow), 64'd0);
    check_output("rst_out_sat", 64'(out_sat), 64'd0);
    check_output("rst_ovf_count", 64'(ovf_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    $display("[TB] directed add/sub/saturate beats");
    apply_stimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b00);
    idle();
    check_latency();
    apply_stimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b10);
    apply_stimulus(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b10);
    apply_stimulus(64'd5, 64'd7, 1'b0, 2'b01);
    apply_stimulus(64'd7, 64'd5, 1'b0, 2'b01);
    apply_stimulus(64'd7, 64'd5, 1'b1, 2'b01);
    idle();
    drain();

    $display("[TB] backpressure stream");
    fork
      begin
        for (int i = 0; i < 8; i++) apply_stimulus(64'(i), 64'(i), 1'b0, 2'b00);
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          check_output("stall_in_ready", 64'(in_ready), 64'd0);
          check_output("stall_out_valid", 64'(out_valid), 64'd1);
          check_output("stall_out_s", out_s, 64'd2);
          @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] randomized beats with random backpressure");
    rnd_run = 1;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          apply_stimulus(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
          if ($urandom_range(0, 4) == 0) begin
            idle();
            @(posedge clk);
            #1;
          end
        end
        idle();
        rnd_run = 0;
      end
      begin
        while (rnd_run) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] overflow counter saturation and clear");
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
    for (int n = 0; n < 20; n++) apply_stimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b00);
    idle();
    drain();
    check_output("ovf_count_sat", 64'(ovf_count), 64'd15);

    out_ready = 1'b0;
    apply_stimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b00);
    idle();
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    check_output("held_beat_valid", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
    @(negedge clk);
    check_output("clr_wins", 64'(ovf_count), 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] reset with beats in flight");
    apply_stimulus(64'd100, 64'd200, 1'b0, 2'b00);
    apply_stimulus(64'd300, 64'd400, 1'b0, 2'b00);
    idle();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_output("midrst_out_valid", 64'(out_valid), 64'd0);
    check_output("midrst_out_s", out_s, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_output("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (4) begin
      @(negedge clk);
      check_output("no_stale_beat", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    apply_stimulus(64'h1234, 64'h1111, 1'b0, 2'b00);
    idle();
    check_latency();
    drain();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fxp_addsub_pipe.md
Name: fxp_addsub_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for signed fixed-point words. It is the successor to the fixed 64-bit CLA and adds configurable width and pipeline depth, add/sub and wrap/saturate modes, and a valid/ready handshake. It also keeps a running count of overflow events. It sits in the fixed-point datapath wherever an accumulator or butterfly needs a registered adder with backpressure.

Parameters:
- WIDTH, 64: operand/result width in bits; power of two, 8..128.
- GROUP, 2: width of the leaf ripple-carry groups; power of two, must divide WIDTH.
- PIPE, 2: register stages from input to output, 1..log2(WIDTH/GROUP)+1. All stages sit between lookahead tree levels.
- CNT_W, 16: width of the overflow event counter.

Ports:
- clk  in  1  clock; all registers on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A, signed two's complement.
- in_b  in  WIDTH  operand B, signed two's complement.
- in_carry  in  1  carry-in for add; borrow-in for sub.
- in_mode  in  2  bit0: 0=add, 1=sub; bit1: 0=wrap, 1=saturate.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_s  out  WIDTH  result.
- out_carry  out  1  raw carry-out of the MSB (carry for add, not-borrow for sub).
- out_overflow  out  1  signed overflow of the unsaturated sum.
- out_sat  out  1  result was clamped (overflow AND saturate mode).
- ovf_count  out  CNT_W  count of delivered beats with out_overflow=1.
- clr_count  in  1  synchronous clear of ovf_count.

Behaviour:
- Reset (rst_n=0, asynchronous): all pipeline valid bits are 0 and all data registers are 0. out_valid=0, out_s=0, out_carry=0, out_overflow=0, out_sat=0, ovf_count=0. in_ready=1 on the first edge after release.
- Operand prep: B' = sub ? ~in_b : in_b. Carry-in c0 = sub ? ~in_carry : in_carry, so in_carry=0 gives a plain A-B.
- Arithmetic:
  - g = A & B', p = A ^ B'.
  - Radix-2 group generate/propagate tree over WIDTH/GROUP groups, then carry resolution and GROUP-bit ripple sums.
  - s_raw = A + B' + c0 mod 2^WIDTH.
  - out_carry = carry out of bit WIDTH-1.
  - out_overflow = carry into bit WIDTH-1 XOR out_carry.
- Saturation: when mode bit1=1 and overflow, out_s = A[MSB] ? {1,0...0} : {0,1...1}, and out_sat=1. Otherwise out_s = s_raw and out_sat=0.
- Latency: exactly PIPE cycles from the accepting edge to out_valid, with no stalls. Throughput is one beat per cycle.
- Handshake:
  - Global advance enable: adv = ~out_valid | out_ready. in_ready = adv.
  - A beat is accepted when in_valid & in_ready.
  - A result is delivered when out_valid & out_ready.
  - When adv=0, every stage holds; out_s and the flags stay stable while out_valid=1.
  - Bubbles are not collapsed; an empty stage still waits for adv.
  - in_* are ignored when in_valid=0. The valid bit propagates with the data.
- Mode, in_carry and operand bits travel with their beat. Mixing modes back to back is legal and each beat uses its own mode.
- ovf_count:
  - Increments by 1 on each delivered beat with out_overflow=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - clr_count=1 forces 0 on that edge; clear wins over a simultaneous increment.
- Reset mid-operation: beats in flight are dropped, with no partial output.
- Combinational paths: in_ready depends on out_ready and out_valid only. No combinational path from in_* to out_*.

Test Plan:
- Add wrap, PIPE=2, WIDTH=64: A=0x7FFF_FFFF_FFFF_FFFF, B=1, mode=00, carry=0 -> two cycles later out_s=0x8000_0000_0000_0000, overflow=1, carry=0, sat=0, ovf_count=1.
- Same operands, mode=10 (add saturate) -> out_s=0x7FFF_FFFF_FFFF_FFFF, overflow=1, sat=1. Then A=0x8000_0000_0000_0000, B=0xFFFF_FFFF_FFFF_FFFF -> out_s=0x8000_0000_0000_0000, sat=1, carry=1.
- Sub: A=5, B=7, mode=01, carry=0 -> out_s=0xFFFF_FFFF_FFFF_FFFE, carry=0, overflow=0. Then A=7, B=5 -> out_s=2, carry=1. With in_carry=1 (borrow), A=7, B=5 -> out_s=1.
- Backpressure: stream 8 beats (A=i, B=i) with out_ready low for cycles 3-6. Required: in_ready low in the same cycles, no beat lost or duplicated, outputs 0,2,...,14 in order, out_s stable while stalled.
- Counter: CNT_W=4, 20 overflowing beats -> ovf_count holds 15. Pulse clr_count on the same edge as an overflow delivery -> ovf_count=0.
- Reset: assert rst_n=0 with 2 beats in flight -> out_valid=0 and out_s=0 immediately. After release, no stale beat appears; the first new beat arrives after PIPE cycles.
